// File: rtl/mic_pkg.sv
// mic_pkg: shared sizes, datapath register indices and FSM state encoding for mic_bus_sched.
// The MEMWAIT state exists only when MIC_MEM_WAIT_EN is defined.
package mic_pkg;

  localparam int NREG = 10;
  localparam int SELW = 4;

  localparam int IDX_MAR = 0;
  localparam int IDX_MDR = 1;
  localparam int IDX_PC  = 2;
  localparam int IDX_MBR = 3;
  localparam int IDX_SP  = 4;
  localparam int IDX_LV  = 5;
  localparam int IDX_CPP = 6;
  localparam int IDX_TOS = 7;
  localparam int IDX_OPC = 8;
  localparam int IDX_H   = 9;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DRIVE   = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
`ifdef MIC_MEM_WAIT_EN
  localparam logic [1:0] ST_MEMWAIT = 2'd3;
`endif

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    DRIVE   = ST_DRIVE,
`ifdef MIC_MEM_WAIT_EN
    WRITE   = ST_WRITE,
    MEMWAIT = ST_MEMWAIT
`else
    WRITE   = ST_WRITE
`endif
  } mic_state_e;

endpackage

// File: rtl/mic_sel_dec.sv
// mic_sel_dec: SELW-bit register index to NREG-bit one-hot enable.
// Indices at or beyond NREG decode to all zeros (bus left undriven).
module mic_sel_dec #(
  parameter int NREG = mic_pkg::NREG,
  parameter int SELW = mic_pkg::SELW
) (
  input  logic [SELW-1:0] sel,
  output logic [NREG-1:0] onehot
);

  // Compare at 32 bits so indices above 2**SELW-1 can never alias onto a low bit.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
      assign onehot[gi] = (32'(sel) == gi);
    end
  endgenerate

endmodule

// File: rtl/mic_bus_sched.sv
// mic_bus_sched: sequences one microinstruction through DRIVE/WRITE and optional memory access.
// Define MIC_MEM_WAIT_EN for a MEMWAIT state handshaking on mem_done; otherwise strobes pulse once.
module mic_bus_sched
  import mic_pkg::*;
#(
  parameter int NREG = mic_pkg::NREG,
  parameter int SELW = mic_pkg::SELW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mi_valid,
  output logic            mi_ready,
  input  logic [SELW-1:0] mi_a_sel,
  input  logic [SELW-1:0] mi_b_sel,
  input  logic [NREG-1:0] mi_c_mask,
  input  logic            mi_rd,
  input  logic            mi_wr,
  output logic [NREG-1:0] ena_out_a,
  output logic [NREG-1:0] ena_out_b,
  output logic [NREG-1:0] ena_in,
  output logic            mem_rd,
  output logic            mem_wr,
  input  logic            mem_done,
  output logic            busy
);

  mic_state_e      state_q, state_d;
  logic [SELW-1:0] a_sel_q, a_sel_d, b_sel_q, b_sel_d;
  logic [NREG-1:0] c_mask_q, c_mask_d;
  logic            rd_q, rd_d, wr_q, wr_d;
  logic [NREG-1:0] ena_out_a_q, ena_out_a_d, ena_out_b_q, ena_out_b_d;
  logic [NREG-1:0] ena_in_q, ena_in_d;
  logic            mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d, busy_q, busy_d;
  logic            accept;
  logic [SELW-1:0] a_sel_src, b_sel_src;
  logic [NREG-1:0] dec_a, dec_b;

`ifndef MIC_MEM_WAIT_EN
  logic unused_mem_done;
  assign unused_mem_done = mem_done;
`endif

  assign mi_ready = reset && (state_q == IDLE);
  assign accept   = mi_valid && mi_ready;

  // Decode straight from the inputs on the accept cycle so DRIVE enables are ready on entry.
  assign a_sel_src = accept ? mi_a_sel : a_sel_q;
  assign b_sel_src = accept ? mi_b_sel : b_sel_q;

  mic_sel_dec #(.NREG(NREG), .SELW(SELW)) u_dec_a (.sel(a_sel_src), .onehot(dec_a));
  mic_sel_dec #(.NREG(NREG), .SELW(SELW)) u_dec_b (.sel(b_sel_src), .onehot(dec_b));

  always_comb begin
    state_d     = state_q;
    a_sel_d     = a_sel_q;
    b_sel_d     = b_sel_q;
    c_mask_d    = c_mask_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    ena_out_a_d = '0;
    ena_out_b_d = '0;
    ena_in_d    = '0;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = DRIVE;
          a_sel_d     = mi_a_sel;
          b_sel_d     = mi_b_sel;
          c_mask_d    = mi_c_mask;
          rd_d        = mi_rd;
          wr_d        = mi_wr && !mi_rd;  // read wins; a simultaneous write is dropped
          ena_out_a_d = dec_a;
          ena_out_b_d = dec_b;
        end
      end
      DRIVE: begin
        state_d     = WRITE;
        ena_out_a_d = dec_a;
        ena_out_b_d = dec_b;
        ena_in_d    = c_mask_q;
      end
      WRITE: begin
`ifdef MIC_MEM_WAIT_EN
        if (rd_q || wr_q) begin
          state_d  = MEMWAIT;
          mem_rd_d = rd_q;
          mem_wr_d = wr_q;
        end else begin
          state_d  = IDLE;
        end
`else
        state_d  = IDLE;
        mem_rd_d = rd_q;
        mem_wr_d = wr_q;
`endif
      end
`ifdef MIC_MEM_WAIT_EN
      MEMWAIT: begin
        if (mem_done) begin
          state_d = IDLE;
          if (rd_q) ena_in_d = NREG'(1) << IDX_MDR;
        end else begin
          mem_rd_d = rd_q;
          mem_wr_d = wr_q;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      a_sel_q     <= '0;
      b_sel_q     <= '0;
      c_mask_q    <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      ena_out_a_q <= '0;
      ena_out_b_q <= '0;
      ena_in_q    <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sel_q     <= a_sel_d;
      b_sel_q     <= b_sel_d;
      c_mask_q    <= c_mask_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      ena_out_a_q <= ena_out_a_d;
      ena_out_b_q <= ena_out_b_d;
      ena_in_q    <= ena_in_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      busy_q      <= busy_d;
    end
  end

  assign ena_out_a = ena_out_a_q;
  assign ena_out_b = ena_out_b_q;
  assign ena_in    = ena_in_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mic_bus_sched.sv
// tb_mic_bus_sched: directed and random microinstructions; a per-cycle expected trace is queued
// at issue time and a negedge monitor compares every DUT output against it (MIC_MEM_WAIT_EN aware).
`timescale 1ns/1ps
module tb_mic_bus_sched;

  localparam int NREG    = 10;
  localparam int SELW    = 4;
  localparam int IDX_MDR = 1;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            mi_valid = 1'b0;
  logic            mi_ready;
  logic [SELW-1:0] mi_a_sel = '0;
  logic [SELW-1:0] mi_b_sel = '0;
  logic [NREG-1:0] mi_c_mask = '0;
  logic            mi_rd = 1'b0;
  logic            mi_wr = 1'b0;
  logic [NREG-1:0] ena_out_a, ena_out_b, ena_in;
  logic            mem_rd, mem_wr;
  logic            mem_done = 1'b0;
  logic            busy;

  mic_bus_sched #(.NREG(NREG), .SELW(SELW)) dut (
    .clk(clk), .reset(reset), .mi_valid(mi_valid), .mi_ready(mi_ready),
    .mi_a_sel(mi_a_sel), .mi_b_sel(mi_b_sel), .mi_c_mask(mi_c_mask),
    .mi_rd(mi_rd), .mi_wr(mi_wr), .ena_out_a(ena_out_a), .ena_out_b(ena_out_b),
    .ena_in(ena_in), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_done(mem_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              cyc;
    logic [NREG-1:0] a;
    logic [NREG-1:0] b;
    logic [NREG-1:0] c;
    logic            rd;
    logic            wr;
    logic            busy;
    logic            ready;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [NREG-1:0] oh(int s);
    logic [NREG-1:0] v;
    v = '0;
    if (s >= 0 && s < NREG) v[s] = 1'b1;
    return v;
  endfunction

  function automatic exp_t mk(int c, logic [NREG-1:0] a, logic [NREG-1:0] b, logic [NREG-1:0] i,
                              logic rd, logic wr, logic bz, logic rdy);
    exp_t e;
    e.cyc = c; e.a = a; e.b = b; e.c = i; e.rd = rd; e.wr = wr; e.busy = bz; e.ready = rdy;
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Cycles without a queued record are expected idle: everything 0, ready 1 out of reset.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      cur = mk(cyc, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) cur = exp_q.pop_front();
      if (!reset) cur.ready = 1'b0;
      chk("ena_out_a", 32'(ena_out_a), 32'(cur.a));
      chk("ena_out_b", 32'(ena_out_b), 32'(cur.b));
      chk("ena_in",    32'(ena_in),    32'(cur.c));
      chk("mem_rd",    32'(mem_rd),    32'(cur.rd));
      chk("mem_wr",    32'(mem_wr),    32'(cur.wr));
      chk("busy",      32'(busy),      32'(cur.busy));
      chk("mi_ready",  32'(mi_ready),  32'(cur.ready));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one microinstruction now; returns in the first cycle a new one may be offered.
  // rst_at > 0 pulses reset low in relative cycle rst_at, then sends stray mem_done pulses.
  task automatic issue(int a, int b, logic [NREG-1:0] c, logic rd, logic wr, int dly, int rst_at);
    int   n, last;
    logic rd_e, wr_e;
    exp_t tr[$];
    n    = cyc;
    rd_e = rd;
    wr_e = wr && !rd;
    last = n + 3;
    tr.push_back(mk(n + 1, oh(a), oh(b), '0, 1'b0, 1'b0, 1'b1, 1'b0));
    tr.push_back(mk(n + 2, oh(a), oh(b), c,  1'b0, 1'b0, 1'b1, 1'b0));
`ifdef MIC_MEM_WAIT_EN
    if (rd_e || wr_e) begin
      for (int k = 1; k <= dly; k++)
        tr.push_back(mk(n + 2 + k, '0, '0, '0, rd_e, wr_e, 1'b1, 1'b0));
      tr.push_back(mk(n + 3 + dly, '0, '0, rd_e ? oh(IDX_MDR) : '0, 1'b0, 1'b0, 1'b0, 1'b1));
      last = n + 3 + dly;
    end
`else
    if (rd_e || wr_e) tr.push_back(mk(n + 3, '0, '0, '0, rd_e, wr_e, 1'b0, 1'b1));
`endif
    foreach (tr[i]) if (rst_at == 0 || tr[i].cyc <= n + rst_at) exp_q.push_back(tr[i]);
    $display("txn cycle %0d: a=%0d b=%0d c=0x%03h rd=%0d wr=%0d dly=%0d rst_at=%0d",
             n, a, b, c, rd, wr, dly, rst_at);

    mi_valid  = 1'b1;
    mi_a_sel  = SELW'(a);
    mi_b_sel  = SELW'(b);
    mi_c_mask = c;
    mi_rd     = rd;
    mi_wr     = wr;
    mem_done  = 1'b0;
    step();
    mi_valid  = 1'b0;
    mi_a_sel  = SELW'($urandom);
    mi_b_sel  = SELW'($urandom);
    mi_c_mask = NREG'($urandom);
    mi_rd     = 1'($urandom);
    mi_wr     = 1'($urandom);
    while (cyc < last) begin
      if (rst_at != 0 && cyc == n + rst_at) begin
        reset = 1'b0;
        step();
        reset    = 1'b1;
        mem_done = 1'b1;
        step();
        step();
        mem_done = 1'b0;
        return;
      end
`ifdef MIC_MEM_WAIT_EN
      mem_done = (rd_e || wr_e) && (cyc == n + 2 + dly);
`endif
      step();
    end
    mem_done = 1'b0;
  endtask

  initial begin
    // Offer a transfer while held in reset: it must be ignored.
    reset     = 1'b0;
    mi_valid  = 1'b1;
    mi_a_sel  = 4'd3;
    mi_c_mask = 10'h3ff;
    mi_rd     = 1'b1;
    repeat (3) step();
    reset    = 1'b1;
    mi_valid = 1'b0;
    mi_rd    = 1'b0;
    step();

    issue(2, 7, 10'h001, 1'b0, 1'b0, 1, 0);
    issue(1, 12, 10'h2a5, 1'b0, 1'b0, 1, 0);
    issue(5, 4, 10'h010, 1'b1, 1'b0, 4, 0);
    issue(0, 9, 10'h100, 1'b1, 1'b1, 2, 0);
    issue(6, 3, 10'h0c0, 1'b0, 1'b1, 3, 0);
    issue(8, 15, 10'h200, 1'b0, 1'b0, 1, 0);
`ifdef MIC_MEM_WAIT_EN
    issue(4, 2, 10'h004, 1'b1, 1'b0, 6, 4);
`else
    issue(4, 2, 10'h004, 1'b1, 1'b0, 1, 2);
`endif
    step();

    for (int t = 0; t < 60; t++) begin
      int gap;
      gap = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
      for (int g = 0; g < gap; g++) begin
        mem_done = 1'($urandom);
        step();
      end
      mem_done = 1'b0;
      issue($urandom_range(0, 15), $urandom_range(0, 15), NREG'($urandom),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
            $urandom_range(1, 5), 0);
    end
    repeat (4) step();

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL trace_drained: got %0d pending records expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mic_bus_sched.md
MIC_BUS_SCHED -- requirements
Module: mic_bus_sched

Interface
REQ-001 The block SHALL have parameter NREG, default 10, meaning the number of datapath registers it controls.
REQ-002 The block SHALL have parameter SELW, default 4, meaning the width of the A and B select fields.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
REQ-005 The block SHALL have port mi_valid, input, 1 bit: a microinstruction is offered.
REQ-006 The block SHALL have port mi_ready, output, 1 bit: the block accepts the offered microinstruction this cycle.
REQ-007 The block SHALL have port mi_a_sel, input, SELW bits: index of the register to drive bus A.
REQ-008 The block SHALL have port mi_b_sel, input, SELW bits: index of the register to drive bus B.
REQ-009 The block SHALL have port mi_c_mask, input, NREG bits: registers that load bus C.
REQ-010 The block SHALL have ports mi_rd and mi_wr, input, 1 bit each: memory read or write request.
REQ-011 The block SHALL have port ena_out_a, output, NREG bits: per-register enaOutA, at most one bit high.
REQ-012 The block SHALL have port ena_out_b, output, NREG bits: per-register enaOutB, at most one bit high.
REQ-013 The block SHALL have port ena_in, output, NREG bits: per-register enaIn.
REQ-014 The block SHALL have ports mem_rd and mem_wr, output, 1 bit each: memory strobes.
REQ-015 The block SHALL have port mem_done, input, 1 bit: memory completion.
REQ-016 The block SHALL have port busy, output, 1 bit: a microinstruction is in flight.

Function
REQ-017 All outputs except mi_ready SHALL be registered; mi_ready SHALL be 1 exactly in state IDLE.
REQ-018 The FSM states SHALL be IDLE, DRIVE, WRITE and MEMWAIT.
REQ-019 Transfer SHALL occur on mi_valid&&mi_ready; the fields are latched, and IDLE->DRIVE; with mi_valid=0, IDLE SHALL hold.
REQ-020 In DRIVE (one cycle), ena_out_a SHALL be one-hot of mi_a_sel and ena_out_b one-hot of mi_b_sel; ena_in=0; DRIVE->WRITE.
REQ-021 A select value >= NREG SHALL produce an all-zero enable vector, leaving that bus undriven (high-Z), which is legal.
REQ-022 In WRITE (one cycle), ena_out_a and ena_out_b SHALL hold their DRIVE values and ena_in SHALL equal the latched c_mask.
REQ-023 The register update SHALL occur at the edge ending WRITE, so the latency from accept edge to register capture is 2 cycles.
REQ-024 From WRITE, if mi_rd|mi_wr is latched, the FSM SHALL go ->MEMWAIT; otherwise ->IDLE.
REQ-025 In MEMWAIT, all enables SHALL be 0 and mem_rd/mem_wr SHALL be held high per the latched request until mem_done=1.
REQ-026 On mem_done=1 in MEMWAIT, the FSM SHALL go ->IDLE and deassert the strobes next cycle; on a read, ena_in[IDX_MDR] SHALL pulse for one cycle in that next cycle.
REQ-027 If mi_rd and mi_wr are both latched, the read SHALL take priority: only mem_rd is asserted and the write is dropped.
REQ-028 mem_done seen outside MEMWAIT SHALL be ignored.
REQ-029 busy SHALL equal (state != IDLE).
REQ-030 A new transfer SHALL not be accepted before IDLE, giving back-to-back throughput of one microinstruction per 3 cycles without memory.

Reset
REQ-031 When reset=0 at a rising edge, the FSM SHALL be forced to IDLE, from any state including mid-MEMWAIT.
REQ-032 When reset=0 at a rising edge, ena_out_a, ena_out_b, ena_in, mem_rd, mem_wr and busy SHALL be forced to 0, and latched fields cleared.
REQ-033 While reset=0, mi_ready SHALL be 0, and transfers SHALL be ignored.

Configuration
REQ-034 Macro MIC_MEM_WAIT_EN defined: MEMWAIT behaviour SHALL be as in REQ-025 to REQ-026.
REQ-035 MIC_MEM_WAIT_EN undefined: the MEMWAIT state SHALL be absent, mem_rd/mem_wr SHALL pulse for one cycle in the cycle after WRITE while the FSM is in IDLE, mem_done SHALL be unused, and no MDR load SHALL be issued.

Structure
REQ-036 Package mic_pkg SHALL hold NREG, SELW, register indices IDX_MAR/IDX_MDR/IDX_PC/IDX_MBR/IDX_SP/IDX_LV/IDX_CPP/IDX_TOS/IDX_OPC/IDX_H, and the state enum.
REQ-037 Sub-module mic_sel_dec SHALL decode a SELW-bit index to an NREG-bit one-hot, giving zero when out of range, instantiated twice (A and B).

Verification
REQ-038 The bench SHALL check: a_sel=2, b_sel=7, c_mask=0x001, no mem -> DRIVE: ena_out_a=0x004, ena_out_b=0x080; WRITE: ena_in=0x001; IDLE after 3 cycles.
REQ-039 The bench SHALL check: b_sel=12 -> ena_out_b=0x000 in both DRIVE and WRITE.
REQ-040 The bench SHALL check: mi_rd=1, mem_done after 4 cycles -> mem_rd high 4 cycles, then ena_in=1<<IDX_MDR for one cycle, then mi_ready=1.
REQ-041 The bench SHALL check: mi_rd=mi_wr=1 -> only mem_rd asserted.
REQ-042 The bench SHALL check: reset=0 during MEMWAIT -> next cycle all outputs 0, busy=0; mem_done afterwards is ignored.
REQ-043 The bench SHALL check: MIC_MEM_WAIT_EN undefined with mi_wr=1 -> mem_wr high exactly one cycle, and the next microinstruction is accepted in that cycle.
